// File: rtl/dw_cmp_pkg.sv
// Shared types and helpers for the digit-serial duplex comparator.
package dw_cmp_pkg;

    // Controller states
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // One-hot relation of A to B
    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
    } cmp_res_t;

    localparam cmp_res_t RES_EQ   = '{lt: 1'b0, eq: 1'b1, gt: 1'b0};
    localparam cmp_res_t RES_NONE = '{lt: 1'b0, eq: 1'b0, gt: 1'b0};

    // Number of DIGIT-wide chunks covering a field of the given width
    function automatic int unsigned num_chunks(input int unsigned bits,
                                               input int unsigned digit);
        return bits / digit;
    endfunction

    // Legal parameter combinations; a single-chunk build has no duplex split,
    // so the part1 multiple-of-DIGIT rule only bites when there are >= 2 chunks
    function automatic bit params_legal(input int unsigned width,
                                        input int unsigned p1_width,
                                        input int unsigned digit);
        bit ok;
        ok = 1'b1;
        if (digit < 1 || digit > width)            ok = 1'b0;
        if (digit != 0 && (width % digit) != 0)    ok = 1'b0;
        if (p1_width == 0 || p1_width >= width)    ok = 1'b0;
        if (digit != 0 && digit != width && (p1_width % digit) != 0) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/dw_cmp_digit.sv
// Combinational DIGIT-bit magnitude compare with optional sign-bit inversion.
module dw_cmp_digit
    import dw_cmp_pkg::*;
#(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_flip_msb,
    output cmp_res_t         o_res
);

    localparam logic [DIGIT-1:0] MSB_MASK = DIGIT'(1) << (DIGIT - 1);

    logic [DIGIT-1:0] w_a;
    logic [DIGIT-1:0] w_b;

    // Inverting the sign bit maps two's-complement order onto unsigned order
    assign w_a = i_a ^ (i_flip_msb ? MSB_MASK : '0);
    assign w_b = i_b ^ (i_flip_msb ? MSB_MASK : '0);

    // Unsigned compare of the (possibly adjusted) chunks
    always_comb begin
        o_res = RES_NONE;
        if (w_a < w_b) begin
            o_res.lt = 1'b1;
        end else if (w_a > w_b) begin
            o_res.gt = 1'b1;
        end else begin
            o_res.eq = 1'b1;
        end
    end

endmodule

// File: rtl/dw_cmp_dx_seq.sv
// Digit-serial simplex/duplex comparator: DIGIT bits per cycle, LSB-first,
// start/busy/done handshake.
module dw_cmp_dx_seq
    import dw_cmp_pkg::*;
#(
    parameter int unsigned width    = 24,
    parameter int unsigned p1_width = 16,
    parameter int unsigned DIGIT    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             tc,
    input  logic             dplx,
    output logic             busy,
    output logic             done,
    output logic             lt1,
    output logic             eq1,
    output logic             gt1,
    output logic             lt2,
    output logic             eq2,
    output logic             gt2
);

    localparam int unsigned NCYC  = num_chunks(width, DIGIT);
    localparam int unsigned P1CYC = num_chunks(p1_width, DIGIT);
    localparam int unsigned CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCYC - 1);
    localparam logic [CNT_W-1:0] CNT_P1   = CNT_W'(P1CYC - 1);

    if (!params_legal(width, p1_width, DIGIT)) begin : g_param_check
        $error("dw_cmp_dx_seq: illegal width/p1_width/DIGIT combination");
    end

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [width-1:0] r_a;
    logic [width-1:0] r_b;
    logic             r_tc;
    logic             r_dplx;
    cmp_res_t         r_run;
    cmp_res_t         r_p1;
    cmp_res_t         r_res1;
    cmp_res_t         r_res2;
    logic             r_done;

    logic [DIGIT-1:0] w_chunk_a;
    logic [DIGIT-1:0] w_chunk_b;
    logic             w_last;
    logic             w_split;
    logic             w_flip;
    cmp_res_t         w_dig;
    cmp_res_t         w_next;

    // Operands shift right each cycle, so the active chunk is always the low digit
    assign w_chunk_a = r_a[DIGIT-1:0];
    assign w_chunk_b = r_b[DIGIT-1:0];

    assign w_last  = (r_cnt == CNT_LAST);
    assign w_split = r_dplx && (r_cnt == CNT_P1);
    assign w_flip  = r_tc && (w_last || w_split);

    dw_cmp_digit #(
        .DIGIT(DIGIT)
    ) u_digit (
        .i_a       (w_chunk_a),
        .i_b       (w_chunk_b),
        .i_flip_msb(w_flip),
        .o_res     (w_dig)
    );

    // A differing chunk overrides everything below it; equal chunks keep history
    always_comb begin
        w_next = r_run;
        if (w_chunk_a != w_chunk_b) begin
            w_next = w_dig;
        end
    end

    // Handshake FSM, operand shifting and result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_tc    <= 1'b0;
            r_dplx  <= 1'b0;
            r_run   <= RES_NONE;
            r_p1    <= RES_NONE;
            r_res1  <= RES_NONE;
            r_res2  <= RES_NONE;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_tc    <= tc;
                        r_dplx  <= dplx;
                        r_run   <= RES_EQ;
                        r_p1    <= RES_EQ;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_a   <= r_a >> DIGIT;
                    r_b   <= r_b >> DIGIT;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_res2  <= w_next;
                        r_res1  <= r_dplx ? r_p1 : w_next;
                        r_done  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else if (w_split) begin
                        // part1 is complete: park it and restart part2 from "equal"
                        r_p1  <= w_next;
                        r_run <= RES_EQ;
                    end else begin
                        r_run <= w_next;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = (r_state == RUN);
    assign done = r_done;
    assign lt1  = r_res1.lt;
    assign eq1  = r_res1.eq;
    assign gt1  = r_res1.gt;
    assign lt2  = r_res2.lt;
    assign eq2  = r_res2.eq;
    assign gt2  = r_res2.gt;

endmodule

// File: tb/tb_dw_cmp_dx_seq.sv
// Self-checking bench for dw_cmp_dx_seq using a result/latency scoreboard.
module tb_dw_cmp_dx_seq;

    localparam int W    = 24;
    localparam int P1   = 16;
    localparam int DG   = 4;
    localparam int NCYC = W / DG;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          tc;
    logic          dplx;
    logic          busy;
    logic          done;
    logic          lt1, eq1, gt1, lt2, eq2, gt2;

    typedef struct {
        logic [5:0]  res;      // {lt1,eq1,gt1,lt2,eq2,gt2}
        int unsigned edge_no;  // posedge index after which done must be seen
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    int unsigned pos_cnt = 0;

    dw_cmp_dx_seq #(
        .width   (W),
        .p1_width(P1),
        .DIGIT   (DG)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .tc   (tc),
        .dplx (dplx),
        .busy (busy),
        .done (done),
        .lt1  (lt1),
        .eq1  (eq1),
        .gt1  (gt1),
        .lt2  (lt2),
        .eq2  (eq2),
        .gt2  (gt2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pos_cnt <= pos_cnt + 1;

    // Field value as a signed integer: zero- or sign-extended
    function automatic longint fval(input logic [W-1:0] x, input int lo,
                                    input int n, input logic s);
        logic [63:0] v;
        logic [63:0] m;
        m = (64'd1 << n) - 64'd1;
        v = 64'(x >> lo) & m;
        if (s && v[n-1]) v = v | ~m;
        return longint'(v);
    endfunction

    function automatic logic [2:0] rel(input longint x, input longint y);
        if (x < y) return 3'b100;
        if (x > y) return 3'b001;
        return 3'b010;
    endfunction

    function automatic logic [5:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mtc, input logic mdp);
        logic [2:0] r1, r2;
        if (mdp) begin
            r1 = rel(fval(ma, 0, P1, mtc), fval(mb, 0, P1, mtc));
            r2 = rel(fval(ma, P1, W - P1, mtc), fval(mb, P1, W - P1, mtc));
        end else begin
            r2 = rel(fval(ma, 0, W, mtc), fval(mb, 0, W, mtc));
            r1 = r2;
        end
        return {r1, r2};
    endfunction

    // Must be entered at a negedge; start is high across exactly one posedge
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic itc, input logic idp, output int unsigned acc);
        exp_t e;
        a = ia; b = ib; tc = itc; dplx = idp; start = 1'b1;
        acc = pos_cnt + 1;
        e.res = model(ia, ib, itc, idp);
        e.edge_no = acc + NCYC;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain(output bit to);
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        to = (sb.size() != 0);
        @(negedge clk);
    endtask

    // Scoreboard consumer: every done must match the oldest outstanding request
    always @(negedge clk) begin
        logic [5:0] obs;
        exp_t e;
        if (!rst && done) begin
            obs = {lt1, eq1, gt1, lt2, eq2, gt2};
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done at_edge=%0d obs=%b required=no_done", pos_cnt, obs);
            end else begin
                e = sb.pop_front();
                if (obs !== e.res) begin
                    bad++;
                    $display("FAIL result obs=%b required=%b", obs, e.res);
                end
                total++;
                if (pos_cnt !== e.edge_no) begin
                    bad++;
                    $display("FAIL latency done_edge=%0d required=%0d", pos_cnt, e.edge_no);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; tc = 1'b0; dplx = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({busy, done, lt1, eq1, gt1, lt2, eq2, gt2} !== 8'h00) begin
            bad++;
            $display("FAIL reset_state obs=%b required=%b",
                     {busy, done, lt1, eq1, gt1, lt2, eq2, gt2}, 8'h00);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_simplex();
        int unsigned acc;
        bit to;
        issue(24'h800000, 24'h7FFFFF, 1'b0, 1'b0, acc);
        for (int i = 0; i < NCYC; i++) begin
            total++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                bad++;
                $display("FAIL busy_during_run cycle=%0d busy=%b done=%b required busy=1 done=0", i, busy, done);
            end
            @(negedge clk);
        end
        total++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            bad++;
            $display("FAIL done_cycle busy=%b done=%b required busy=0 done=1", busy, done);
        end
        wait_drain(to);
        total++;
        if (to) begin bad++; $display("FAIL simplex_unsigned timeout pending=%0d required=0", sb.size()); end
        repeat (3) @(negedge clk);
        total++;
        if ({done, lt1, eq1, gt1, lt2, eq2, gt2} !== 7'b0001001) begin
            bad++;
            $display("FAIL result_hold obs=%b required=%b", {done, lt1, eq1, gt1, lt2, eq2, gt2}, 7'b0001001);
        end
        issue(24'h800000, 24'h7FFFFF, 1'b1, 1'b0, acc);
        wait_drain(to);
        total++;
        if (to) begin bad++; $display("FAIL simplex_signed timeout pending=%0d required=0", sb.size()); end
    endtask

    task automatic test_duplex();
        int unsigned acc;
        bit to;
        logic [W-1:0] ra, rb;
        logic [W-1:0] msk;
        issue(24'h01FFFF, 24'h010001, 1'b1, 1'b1, acc);
        issue_wait: begin end
        wait_drain(to);
        issue(24'h01FFFF, 24'h010001, 1'b0, 1'b1, acc);
        wait_drain(to);
        issue(24'h7F0000, 24'h800000, 1'b1, 1'b1, acc);
        wait_drain(to);
        issue(24'h008000, 24'h000000, 1'b1, 1'b1, acc);
        wait_drain(to);
        total++;
        if (to) begin bad++; $display("FAIL duplex timeout pending=%0d required=0", sb.size()); end
        for (int i = 0; i < 12; i++) begin
            ra = W'($urandom);
            msk = W'(24'hF) << (4 * $urandom_range(0, NCYC - 1));
            rb = ($urandom_range(0, 1) == 1) ? (ra ^ msk) : W'($urandom);
            issue(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), acc);
            wait_drain(to);
            total++;
            if (to) begin bad++; $display("FAIL random_%0d timeout pending=%0d required=0", i, sb.size()); end
        end
    endtask

    task automatic test_ignore_start();
        int unsigned acc;
        bit to;
        issue(24'h123456, 24'h123456, 1'b0, 1'b1, acc);
        @(negedge clk);
        a = 24'h000000; b = 24'hFFFFFF; tc = 1'b0; dplx = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain(to);
        total++;
        if (to) begin bad++; $display("FAIL ignore_start timeout pending=%0d required=0", sb.size()); end
        repeat (NCYC + 2) @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL ignored_start_busy obs=%b required=0", busy);
        end
    endtask

    task automatic test_back_to_back();
        int unsigned acc;
        int unsigned acc2;
        bit to;
        issue(24'h123456, 24'h123456, 1'b0, 1'b0, acc);
        for (int i = 0; i < 40 && pos_cnt != acc + NCYC; i++) @(negedge clk);
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL b2b_first_done obs=%b required=1", done);
        end
        issue(24'h800000, 24'h7FFFFF, 1'b0, 1'b0, acc2);
        total++;
        if (acc2 !== acc + NCYC + 1) begin
            bad++;
            $display("FAIL b2b_accept_edge obs=%0d required=%0d", acc2, acc + NCYC + 1);
        end
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({busy, lt1, eq1, gt1, lt2, eq2, gt2} !== 7'b1010010) begin
            bad++;
            $display("FAIL b2b_hold_during_run obs=%b required=%b",
                     {busy, lt1, eq1, gt1, lt2, eq2, gt2}, 7'b1010010);
        end
        wait_drain(to);
        total++;
        if (to) begin bad++; $display("FAIL b2b timeout pending=%0d required=0", sb.size()); end
    endtask

    task automatic test_reset_abort();
        int unsigned acc;
        bit to;
        issue(24'h000001, 24'h000002, 1'b0, 1'b0, acc);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({busy, done, lt1, eq1, gt1, lt2, eq2, gt2} !== 8'h00) begin
            bad++;
            $display("FAIL async_abort obs=%b required=%b",
                     {busy, done, lt1, eq1, gt1, lt2, eq2, gt2}, 8'h00);
        end
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (NCYC + 3) @(negedge clk);
        total++;
        if ({busy, lt2, eq2, gt2} !== 4'b0000) begin
            bad++;
            $display("FAIL abort_no_result obs=%b required=0000", {busy, lt2, eq2, gt2});
        end
        issue(24'hFFFFFE, 24'h000003, 1'b1, 1'b0, acc);
        wait_drain(to);
        total++;
        if (to) begin bad++; $display("FAIL after_reset timeout pending=%0d required=0", sb.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time_limit reached required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_simplex();
        test_duplex();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
